// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pkg
//  Description : Shared constants for the two-client SDRAM port arbiter:
//                parameter defaults, FSM state codes and grant encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int BL_DEFAULT     = 8;
    localparam int ADDR_W_DEFAULT = 24;
    localparam int DATA_W_DEFAULT = 16;

    // Arbiter FSM state codes
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE_RD = 3'd1;
    localparam logic [2:0] ST_DATA_RD  = 3'd2;
    localparam logic [2:0] ST_ISSUE_WR = 3'd3;
    localparam logic [2:0] ST_DATA_WR  = 3'd4;

    // Port ownership encodings (bit0 = read client, bit1 = write client)
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_RD   = 2'b01;
    localparam logic [1:0] GNT_WR   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin pick between read and write requesters.
//                Holds the last-grant flag, which starts as "write" so the
//                read client wins the first contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import sdram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,       // arbitration allowed this cycle
    input  logic       req_rd_i,
    input  logic       req_wr_i,
    output logic [1:0] gnt_o       // GNT_NONE / GNT_RD / GNT_WR
);

    logic last_wr_q;
    logic last_wr_d;

    // Pick a requester; on contention favour the one not served last
    always_comb begin
        gnt_o = GNT_NONE;
        if (en_i) begin
            if (req_rd_i && req_wr_i) begin
                gnt_o = last_wr_q ? GNT_RD : GNT_WR;
            end else if (req_rd_i) begin
                gnt_o = GNT_RD;
            end else if (req_wr_i) begin
                gnt_o = GNT_WR;
            end
        end
    end

    // Every issued grant is accepted immediately, so it updates the flag
    always_comb begin
        last_wr_d = last_wr_q;
        if (gnt_o == GNT_RD) begin
            last_wr_d = 1'b0;
        end else if (gnt_o == GNT_WR) begin
            last_wr_d = 1'b1;
        end
    end

    // Last-grant flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_q <= 1'b1;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arb
//  Description : Arbitrates one read client and one write client onto a
//                single SDRAM controller port. Each grant issues one command
//                and then forwards BL data beats combinationally, with no
//                buffering, before returning to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int BL     = BL_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic              sdram_clk,
    input  logic              rst,
    // read client
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_avalid,
    output logic              rd_aready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    // write client
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_avalid,
    output logic              wr_aready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // controller
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_we,
    output logic              sd_avalid,
    input  logic              sd_aready,
    output logic [DATA_W-1:0] sd_wdata,
    output logic              sd_wvalid,
    input  logic              sd_wready,
    input  logic [DATA_W-1:0] sd_rdata,
    input  logic              sd_rvalid,
    output logic              sd_rready,
    // status
    output logic              busy,
    output logic [1:0]        grant
);

    // Beat index of the final beat in a burst
    localparam logic [3:0] LAST_BEAT = 4'(BL - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [1:0]        pick;

    rr_arb2 u_rr_arb2 (
        .clk      (sdram_clk),
        .rst      (rst),
        .en_i     (state_q == ST_IDLE),
        .req_rd_i (rd_avalid),
        .req_wr_i (wr_avalid),
        .gnt_o    (pick)
    );

    assign sd_addr = addr_q;
    assign sd_we   = we_q;
    assign busy    = (state_q != ST_IDLE);

    // Next-state, beat counting and combinational data-path steering
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        rd_aready = 1'b0;
        wr_aready = 1'b0;
        sd_avalid = 1'b0;
        rd_data   = '0;
        rd_valid  = 1'b0;
        sd_rready = 1'b0;
        sd_wdata  = '0;
        sd_wvalid = 1'b0;
        wr_ready  = 1'b0;
        grant     = GNT_NONE;
        case (state_q)
            ST_IDLE: begin
                rd_aready = (pick == GNT_RD);
                wr_aready = (pick == GNT_WR);
                if (pick == GNT_RD) begin
                    addr_d  = rd_addr;
                    we_d    = 1'b0;
                    state_d = ST_ISSUE_RD;
                end else if (pick == GNT_WR) begin
                    addr_d  = wr_addr;
                    we_d    = 1'b1;
                    state_d = ST_ISSUE_WR;
                end
            end
            ST_ISSUE_RD: begin
                grant     = GNT_RD;
                sd_avalid = 1'b1;
                if (sd_aready) begin
                    state_d = ST_DATA_RD;
                end
            end
            ST_DATA_RD: begin
                grant     = GNT_RD;
                rd_data   = sd_rdata;
                rd_valid  = sd_rvalid;
                sd_rready = rd_ready;
                if (sd_rvalid && rd_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_ISSUE_WR: begin
                grant     = GNT_WR;
                sd_avalid = 1'b1;
                if (sd_aready) begin
                    state_d = ST_DATA_WR;
                end
            end
            ST_DATA_WR: begin
                grant     = GNT_WR;
                sd_wdata  = wr_data;
                sd_wvalid = wr_valid;
                wr_ready  = sd_wready;
                if (wr_valid && sd_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, beat counter and latched command registers
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arb
//  Description : Scoreboard bench for sdram_port_arb (BL=8 instance plus a
//                BL=1 instance). Expected commands and beats are queued when
//                stimulus is issued; a monitor pops them on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arb;

    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    // BL=8 instance
    logic [AW-1:0] rd_addr, wr_addr, sd_addr;
    logic          rd_avalid, rd_aready, rd_valid, rd_ready;
    logic [DW-1:0] rd_data, wr_data, sd_wdata, sd_rdata;
    logic          wr_avalid, wr_aready, wr_valid, wr_ready;
    logic          sd_we, sd_avalid, sd_aready, sd_wvalid, sd_wready, sd_rvalid, sd_rready;
    logic          busy;
    logic [1:0]    grant;
    // BL=1 instance
    logic [AW-1:0] b_rd_addr, b_wr_addr, b_sd_addr;
    logic          b_rd_avalid, b_rd_aready, b_rd_valid, b_rd_ready;
    logic [DW-1:0] b_rd_data, b_wr_data, b_sd_wdata, b_sd_rdata;
    logic          b_wr_avalid, b_wr_aready, b_wr_valid, b_wr_ready;
    logic          b_sd_we, b_sd_avalid, b_sd_aready, b_sd_wvalid, b_sd_wready, b_sd_rvalid, b_sd_rready;
    logic          b_busy;
    logic [1:0]    b_grant;

    sdram_port_arb #(.BL(8), .ADDR_W(AW), .DATA_W(DW)) dut (
        .sdram_clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_addr(wr_addr), .wr_avalid(wr_avalid), .wr_aready(wr_aready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_avalid(sd_avalid), .sd_aready(sd_aready),
        .sd_wdata(sd_wdata), .sd_wvalid(sd_wvalid), .sd_wready(sd_wready),
        .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid), .sd_rready(sd_rready),
        .busy(busy), .grant(grant)
    );

    sdram_port_arb #(.BL(1), .ADDR_W(AW), .DATA_W(DW)) dut_bl1 (
        .sdram_clk(clk), .rst(rst),
        .rd_addr(b_rd_addr), .rd_avalid(b_rd_avalid), .rd_aready(b_rd_aready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .wr_addr(b_wr_addr), .wr_avalid(b_wr_avalid), .wr_aready(b_wr_aready),
        .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .sd_addr(b_sd_addr), .sd_we(b_sd_we), .sd_avalid(b_sd_avalid), .sd_aready(b_sd_aready),
        .sd_wdata(b_sd_wdata), .sd_wvalid(b_sd_wvalid), .sd_wready(b_sd_wready),
        .sd_rdata(b_sd_rdata), .sd_rvalid(b_sd_rvalid), .sd_rready(b_sd_rready),
        .busy(b_busy), .grant(b_grant)
    );

    // Controller read source and write client: each advances only on its handshake
    int unsigned rbeat, wbeat;
    always @(posedge clk) begin
        if (rst) begin
            rbeat <= 0;
            wbeat <= 0;
        end else begin
            if (sd_rvalid && sd_rready) rbeat <= rbeat + 1;
            if (wr_valid && wr_ready)   wbeat <= wbeat + 1;
        end
    end
    assign sd_rdata = 16'hA000 + rbeat[15:0];
    assign wr_data  = 16'h0001 + wbeat[15:0];

    // Scoreboard
    logic [AW:0]   cmd_q[$];
    logic [DW-1:0] rdq[$];
    logic [DW-1:0] wrq[$];
    int n_vec = 0, n_fail = 0;
    int rd_seen = 0, wr_seen = 0, cmd_seen = 0;
    int rd_push = 0, wr_push = 0;
    logic tog = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every handshake against the queued expectation
    always @(negedge clk) begin
        logic [AW:0]   c;
        logic [DW-1:0] d;
        check("grant_not_11", 32'(grant == 2'b11), 32'd0);
        check("busy_eq_grant", 32'(busy), 32'(grant != 2'b00));
        if (sd_avalid && sd_aready) begin
            cmd_seen++;
            if (cmd_q.size() == 0) check("cmd_unexpected", 32'({sd_we, sd_addr}), 32'hFFFFFFFF);
            else begin c = cmd_q.pop_front(); check("cmd", 32'({sd_we, sd_addr}), 32'(c)); end
        end
        if (rd_valid && rd_ready) begin
            rd_seen++;
            if (rdq.size() == 0) check("rd_unexpected", 32'(rd_data), 32'hFFFFFFFF);
            else begin d = rdq.pop_front(); check("rd_beat", 32'(rd_data), 32'(d)); end
        end
        if (sd_wvalid && sd_wready) begin
            wr_seen++;
            if (wrq.size() == 0) check("wr_unexpected", 32'(sd_wdata), 32'hFFFFFFFF);
            else begin d = wrq.pop_front(); check("wr_beat", 32'(sd_wdata), 32'(d)); end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) sd_wready = ~sd_wready;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; rd_avalid = 1'b0; wr_avalid = 1'b0;
        b_rd_avalid = 1'b0; b_wr_avalid = 1'b0; tog = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
        cmd_q.delete(); rdq.delete(); wrq.delete();
        rd_seen = 0; wr_seen = 0; cmd_seen = 0; rd_push = 0; wr_push = 0;
    endtask

    task automatic push_cmd(input logic we, input logic [AW-1:0] a);
        cmd_q.push_back({we, a});
    endtask

    task automatic push_rd(input int n);
        for (int i = 0; i < n; i++) begin rdq.push_back(16'hA000 + 16'(rd_push)); rd_push++; end
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++) begin wrq.push_back(16'h0001 + 16'(wr_push)); wr_push++; end
    endtask

    task automatic wait_idle(input int bound, input string name, output int k);
        k = 0;
        @(negedge clk);
        while (busy && k < bound) begin cyc(); @(negedge clk); k++; end
        if (busy) check(name, 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k, acc;
        rd_addr = '0; wr_addr = '0; rd_ready = 1'b1; wr_valid = 1'b1;
        sd_aready = 1'b1; sd_wready = 1'b1; sd_rvalid = 1'b1;
        b_rd_addr = 24'h000AAA; b_wr_addr = 24'h000BBB; b_rd_ready = 1'b1; b_wr_valid = 1'b1;
        b_wr_data = 16'hC3C3; b_sd_aready = 1'b1; b_sd_wready = 1'b1; b_sd_rvalid = 1'b1;
        b_sd_rdata = 16'h5A5A;

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sd_addr", 32'(sd_addr), 32'd0);
        check("rst_sd_we", 32'(sd_we), 32'd0);
        check("rst_sd_avalid", 32'(sd_avalid), 32'd0);
        check("rst_arready", 32'({rd_aready, wr_aready}), 32'd0);
        check("rst_datapath", 32'({rd_valid, sd_rready, sd_wvalid, wr_ready}), 32'd0);
        check("rst_data", 32'({rd_data, sd_wdata}), 32'd0);

        // Single read burst
        cyc();
        rd_addr = 24'h000100; rd_avalid = 1'b1;
        push_cmd(1'b0, 24'h000100); push_rd(8);
        @(negedge clk);
        check("rd1_aready", 32'(rd_aready), 32'd1);
        check("rd1_idle_grant", 32'(grant), 32'd0);
        check("rd1_no_avalid_yet", 32'(sd_avalid), 32'd0);
        cyc(); rd_avalid = 1'b0;
        @(negedge clk);
        check("rd1_sd_avalid", 32'(sd_avalid), 32'd1);
        check("rd1_sd_we", 32'(sd_we), 32'd0);
        check("rd1_sd_addr", 32'(sd_addr), 32'h000100);
        check("rd1_grant", 32'(grant), 32'd1);
        check("rd1_aready_busy", 32'(rd_aready), 32'd0);
        wait_idle(40, "rd1_timeout", k);
        check("rd1_idle_latency", 32'(k), 32'd8);
        check("rd1_beats", 32'(rd_seen), 32'd8);

        // Contention from reset: R first, then strict alternation
        do_reset(2);
        rd_addr = 24'h000300; wr_addr = 24'h000400; rd_avalid = 1'b1; wr_avalid = 1'b1;
        push_cmd(1'b0, 24'h000300); push_cmd(1'b1, 24'h000400);
        push_cmd(1'b0, 24'h000300); push_cmd(1'b1, 24'h000400);
        push_rd(16); push_wr(16);
        @(negedge clk);
        check("cont_rd_first", 32'({rd_aready, wr_aready}), 32'b10);
        acc = 1; k = 0;
        while (!wr_aready && k < 40) begin cyc(); @(negedge clk); k++; end
        check("cont_wr_gap", 32'(k), 32'd10);
        acc = 2;
        while (acc < 4 && k < 200) begin
            cyc(); @(negedge clk); k++;
            if ((rd_avalid && rd_aready) || (wr_avalid && wr_aready)) acc++;
        end
        check("cont_accepts", 32'(acc), 32'd4);
        cyc(); rd_avalid = 1'b0; wr_avalid = 1'b0;
        wait_idle(40, "cont_timeout", k);
        check("cont_cmds", 32'(cmd_seen), 32'd4);
        check("cont_rd_beats", 32'(rd_seen), 32'd16);
        check("cont_wr_beats", 32'(wr_seen), 32'd16);

        // Write burst with sd_wready toggling each cycle
        do_reset(2);
        wr_addr = 24'h000200; wr_avalid = 1'b1; sd_wready = 1'b0; tog = 1'b1;
        push_cmd(1'b1, 24'h000200); push_wr(8);
        @(negedge clk);
        check("wr_aready", 32'(wr_aready), 32'd1);
        cyc(); wr_avalid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (grant == 2'b10 && !sd_avalid) check("wr_ready_mirror", 32'(wr_ready), 32'(sd_wready));
            cyc();
        end
        check("wr_idle", 32'(busy), 32'd0);
        check("wr_beats", 32'(wr_seen), 32'd8);
        tog = 1'b0; sd_wready = 1'b1;

        // Read with rd_ready stalled for 3 cycles mid-burst
        do_reset(2);
        rd_addr = 24'h000500; rd_avalid = 1'b1;
        push_cmd(1'b0, 24'h000500); push_rd(8);
        cyc(); rd_avalid = 1'b0;
        k = 0;
        while (rd_seen < 3 && k < 30) begin cyc(); k++; end
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_sd_rready", 32'(sd_rready), 32'd0);
            check("stall_rd_valid", 32'(rd_valid), 32'd1);
            cyc();
        end
        check("stall_held", 32'(rd_seen), 32'd3);
        rd_ready = 1'b1;
        wait_idle(40, "stall_timeout", k);
        check("stall_beats", 32'(rd_seen), 32'd8);

        // Reset during write beat 4
        do_reset(2);
        wr_addr = 24'h000600; wr_avalid = 1'b1;
        push_cmd(1'b1, 24'h000600); push_wr(8);
        cyc(); wr_avalid = 1'b0;
        k = 0;
        while (wr_seen < 3 && k < 30) begin cyc(); k++; end
        do_reset(1);
        @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_sd_addr", 32'(sd_addr), 32'd0);
        check("mrst_sd_we", 32'(sd_we), 32'd0);
        check("mrst_outs", 32'({sd_avalid, sd_wvalid, wr_ready, rd_valid, sd_rready}), 32'd0);
        check("mrst_wdata", 32'(sd_wdata), 32'd0);
        cyc(); rd_addr = 24'h000700; wr_addr = 24'h000800; rd_avalid = 1'b1; wr_avalid = 1'b1;
        @(negedge clk);
        check("mrst_rd_first", 32'({rd_aready, wr_aready}), 32'b10);
        do_reset(2);

        // BL=1 instance: one handshake per burst
        b_rd_avalid = 1'b1;
        @(negedge clk);
        check("bl1_rd_aready", 32'(b_rd_aready), 32'd1);
        cyc(); b_rd_avalid = 1'b0;
        @(negedge clk);
        check("bl1_rd_issue", 32'({b_sd_avalid, b_sd_we, b_grant}), 32'b1001);
        cyc();
        @(negedge clk);
        check("bl1_rd_beat", 32'({b_rd_valid, b_rd_data}), 32'h15A5A);
        cyc();
        @(negedge clk);
        check("bl1_rd_done", 32'(b_busy), 32'd0);
        cyc(); b_wr_avalid = 1'b1;
        @(negedge clk);
        check("bl1_wr_aready", 32'(b_wr_aready), 32'd1);
        cyc(); b_wr_avalid = 1'b0;
        @(negedge clk);
        check("bl1_wr_issue", 32'({b_sd_avalid, b_sd_we, b_grant}), 32'b1110);
        cyc();
        @(negedge clk);
        check("bl1_wr_beat", 32'({b_sd_wvalid, b_wr_ready, b_sd_wdata}), 32'h3C3C3);
        cyc();
        @(negedge clk);
        check("bl1_wr_done", 32'(b_busy), 32'd0);

        check("left_cmds", 32'(cmd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
